// File: rtl/led_pulse_controller.sv
// Turns one-clock event pulses into visible blinks on an active-low LED,
// queueing events that arrive while a blink or its dark gap is in progress.
module led_pulse_controller #(
    parameter int ON_CYCLES   = 2048,
    parameter int OFF_CYCLES  = 2048,
    parameter int MAX_PENDING = 7
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               eventIn,
    input  logic                               levelIn,
    output logic                               ledOut,
    output logic                               busy,
    output logic                               overflow,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pendingCount
);

    localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int PW      = $clog2(MAX_PENDING + 1);

    localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

    typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

    state_t          state;
    state_t          state_nx;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_nx;
    logic [PW-1:0]   pend_nx;
    logic            ovf_nx;
    logic            take_queued;
    logic            queue_evt;

    always_comb begin
        state_nx    = state;
        timer_nx    = '0;
        take_queued = 1'b0;
        case (state)
            IDLE: begin
                // A leftover queue entry (event coincident with the GAP exit)
                // starts immediately, exactly like a GAP exit with work pending.
                if (pendingCount != '0) begin
                    state_nx    = ON;
                    take_queued = 1'b1;
                end else if (eventIn) begin
                    state_nx = ON;
                end
            end
            ON: begin
                if (timer == ON_LAST) state_nx = GAP;
                else                  timer_nx = timer + 1'b1;
            end
            GAP: begin
                if (timer == OFF_LAST) begin
                    if (pendingCount != '0) begin
                        state_nx    = ON;
                        take_queued = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Only an event seen in IDLE with an empty queue bypasses the queue.
        queue_evt = eventIn && !(state == IDLE && pendingCount == '0);
        pend_nx   = pendingCount;
        ovf_nx    = 1'b0;
        if (queue_evt && !take_queued) begin
            if (pendingCount == PEND_MAX) ovf_nx  = 1'b1;
            else                          pend_nx = pendingCount + 1'b1;
        end else if (!queue_evt && take_queued) begin
            pend_nx = pendingCount - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            timer        <= '0;
            ledOut       <= 1'b1;
            busy         <= 1'b0;
            overflow     <= 1'b0;
            pendingCount <= '0;
        end else begin
            state        <= state_nx;
            timer        <= timer_nx;
            ledOut       <= ~((state_nx == ON) | levelIn);
            busy         <= (state_nx != IDLE);
            overflow     <= ovf_nx;
            pendingCount <= pend_nx;
        end
    end

endmodule

// File: tb/tb_led_pulse_controller.sv
// Bench for led_pulse_controller: fixed vector tables, corner sequences and
// random traffic against a timeline-based model of blinks and the queue.
module tb_led_pulse_controller;

    localparam int ON  = 4;
    localparam int OFF = 3;
    localparam int MAXP = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       eventIn = 1'b0;
    logic       levelIn = 1'b0;
    logic       ledOut;
    logic       busy;
    logic       overflow;
    logic [1:0] pendingCount;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // model: a blink started at edge m_start is lit for ON edges, and the
    // controller is free again at edge m_start+ON+OFF
    bit m_active = 0;
    int m_start = 0;
    int m_pend = 0;
    bit m_ovf = 0;
    bit m_led = 1;

    typedef struct {
        bit ev;
        bit lv;
        bit led;
        bit bsy;
        bit ovf;
        int pend;
    } vec_t;

    vec_t single_tbl[$];
    vec_t queue_tbl[$];

    led_pulse_controller #(
        .ON_CYCLES(ON),
        .OFF_CYCLES(OFF),
        .MAX_PENDING(MAXP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .eventIn(eventIn),
        .levelIn(levelIn),
        .ledOut(ledOut),
        .busy(busy),
        .overflow(overflow),
        .pendingCount(pendingCount)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(bit ev, bit lv, bit led, bit bsy, bit ovf, int pend);
        vec_t v;
        v.ev = ev; v.lv = lv; v.led = led; v.bsy = bsy; v.ovf = ovf; v.pend = pend;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at edge %0d: actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_pend = 0; m_ovf = 0; m_led = 1;
    endtask

    task automatic model_edge(input bit ev, input bit lv);
        bit prev_idle;
        bit took;
        int pend0;
        prev_idle = !m_active;
        pend0 = m_pend;
        took = 0;
        m_ovf = 0;
        if (m_active && cyc == m_start + ON + OFF) begin
            if (m_pend > 0) begin
                m_start = cyc; m_pend--; took = 1;
            end else begin
                m_active = 0;
            end
        end else if (!m_active && m_pend > 0) begin
            m_active = 1; m_start = cyc; m_pend--; took = 1;
        end
        if (ev) begin
            if (prev_idle && pend0 == 0) begin
                m_active = 1; m_start = cyc;
            end else if (took) begin
                m_pend++;
            end else if (m_pend == MAXP) begin
                m_ovf = 1;
            end else begin
                m_pend++;
            end
        end
        m_led = !((m_active && (cyc - m_start) < ON) || lv);
    endtask

    task automatic step(input bit ev, input bit lv);
        eventIn = ev;
        levelIn = lv;
        @(posedge clk);
        cyc++;
        model_edge(ev, lv);
        #1;
        check("model_led", int'(ledOut), int'(m_led));
        check("model_busy", int'(busy), int'(m_active));
        check("model_ovf", int'(overflow), int'(m_ovf));
        check("model_pend", int'(pendingCount), m_pend);
    endtask

    task automatic run_table(input string tag, input vec_t t[$]);
        for (int i = 0; i < t.size(); i++) begin
            step(t[i].ev, t[i].lv);
            check($sformatf("%s[%0d].led", tag, i), int'(ledOut), int'(t[i].led));
            check($sformatf("%s[%0d].busy", tag, i), int'(busy), int'(t[i].bsy));
            check($sformatf("%s[%0d].ovf", tag, i), int'(overflow), int'(t[i].ovf));
            check($sformatf("%s[%0d].pend", tag, i), int'(pendingCount), t[i].pend);
        end
    endtask

    initial begin
        // single event: 4 lit, 3 dark-busy, then idle
        single_tbl.push_back(mk(1, 0, 0, 1, 0, 0));
        single_tbl.push_back(mk(0, 0, 0, 1, 0, 0));
        single_tbl.push_back(mk(0, 0, 0, 1, 0, 0));
        single_tbl.push_back(mk(0, 0, 0, 1, 0, 0));
        single_tbl.push_back(mk(0, 0, 1, 1, 0, 0));
        single_tbl.push_back(mk(0, 0, 1, 1, 0, 0));
        single_tbl.push_back(mk(0, 0, 1, 1, 0, 0));
        single_tbl.push_back(mk(0, 0, 1, 0, 0, 0));

        // four back-to-back events: third queued entry overflows
        queue_tbl.push_back(mk(1, 0, 0, 1, 0, 0));
        queue_tbl.push_back(mk(1, 0, 0, 1, 0, 1));
        queue_tbl.push_back(mk(1, 0, 0, 1, 0, 2));
        queue_tbl.push_back(mk(1, 0, 0, 1, 1, 2));
        queue_tbl.push_back(mk(0, 0, 1, 1, 0, 2));
        queue_tbl.push_back(mk(0, 0, 1, 1, 0, 2));
        queue_tbl.push_back(mk(0, 0, 1, 1, 0, 2));
        queue_tbl.push_back(mk(0, 0, 0, 1, 0, 1));
        queue_tbl.push_back(mk(0, 0, 0, 1, 0, 1));
        queue_tbl.push_back(mk(0, 0, 0, 1, 0, 1));
        queue_tbl.push_back(mk(0, 0, 0, 1, 0, 1));
        queue_tbl.push_back(mk(0, 0, 1, 1, 0, 1));
        queue_tbl.push_back(mk(0, 0, 1, 1, 0, 1));
        queue_tbl.push_back(mk(0, 0, 1, 1, 0, 1));
        queue_tbl.push_back(mk(0, 0, 0, 1, 0, 0));
        queue_tbl.push_back(mk(0, 0, 0, 1, 0, 0));
        queue_tbl.push_back(mk(0, 0, 0, 1, 0, 0));
        queue_tbl.push_back(mk(0, 0, 0, 1, 0, 0));
        queue_tbl.push_back(mk(0, 0, 1, 1, 0, 0));
        queue_tbl.push_back(mk(0, 0, 1, 1, 0, 0));
        queue_tbl.push_back(mk(0, 0, 1, 1, 0, 0));
        queue_tbl.push_back(mk(0, 0, 1, 0, 0, 0));

        // reset with the clock running
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_led", int'(ledOut), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_pend", int'(pendingCount), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        run_table("single", single_tbl);
        run_table("queue", queue_tbl);

        // asynchronous reset in the middle of a blink with a queued entry
        step(1, 0);
        step(1, 0);
        step(0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_led", int'(ledOut), 1);
        check("arst_pend", int'(pendingCount), 0);
        check("arst_busy", int'(busy), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // event coincident with GAP exit, one entry queued
        step(1, 0);
        step(1, 0);
        repeat (5) step(0, 0);
        step(1, 0);
        check("coinc1_pend", int'(pendingCount), 1);
        check("coinc1_ovf", int'(overflow), 0);
        check("coinc1_led", int'(ledOut), 0);
        repeat (20) step(0, 0);

        // event coincident with GAP exit, queue full
        step(1, 0);
        step(1, 0);
        step(1, 0);
        repeat (4) step(0, 0);
        step(1, 0);
        check("coincfull_pend", int'(pendingCount), 2);
        check("coincfull_ovf", int'(overflow), 0);
        repeat (30) step(0, 0);

        // event coincident with GAP exit, empty queue: brief idle then blink
        step(1, 0);
        repeat (6) step(0, 0);
        step(1, 0);
        check("coinc0_pend", int'(pendingCount), 1);
        check("coinc0_busy", int'(busy), 0);
        step(0, 0);
        check("coinc0_restart_led", int'(ledOut), 0);
        check("coinc0_restart_pend", int'(pendingCount), 0);
        repeat (8) step(0, 0);

        // levelIn during GAP, queued blink still starts on the GAP boundary
        step(1, 0);
        step(1, 0);
        step(0, 0);
        step(0, 0);
        step(0, 1);
        check("lvl_gap_on", int'(ledOut), 0);
        step(0, 1);
        step(0, 0);
        check("lvl_release", int'(ledOut), 1);
        check("lvl_release_busy", int'(busy), 1);
        step(0, 0);
        check("lvl_next_blink", int'(ledOut), 0);
        repeat (8) step(0, 0);

        // steady-on with no events
        for (int i = 0; i < 10; i++) begin
            step(0, 1);
            check("idle_lvl_led", int'(ledOut), 0);
            check("idle_lvl_busy", int'(busy), 0);
        end
        step(0, 0);
        check("idle_lvl_off", int'(ledOut), 1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
        end
        repeat (30) step(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_pulse_controller.md
Name: led_pulse_controller

Overview:
- Output-side counterpart to the front-panel button debouncer.
- Accepts one-clock active-high event pulses from internal logic, such as a debounced press or a ROM-select strobe.
- Turns each event into a human-visible blink on an active-low LED pin: a fixed on-time followed by a fixed dark gap.
- Events arriving during a blink are queued, up to a limit, so no press goes unacknowledged.

Parameters:
- ON_CYCLES, 2048: number of clock cycles ledOut is held low per blink; must be >= 1.
- OFF_CYCLES, 2048: number of clock cycles ledOut is held high after each blink before the next queued blink; must be >= 1.
- MAX_PENDING, 7: maximum number of queued (not yet started) blinks; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- eventIn  input  1  active-high, one-clock event pulse, synchronous to clk.
- levelIn  input  1  active-high steady-on request; forces the LED on while high.
- ledOut  output  1  active-low LED drive (0 = lit); registered.
- busy  output  1  1 while a blink or gap is in progress; registered.
- overflow  output  1  1 for one clock when an event is dropped because the queue is full; registered.
- pendingCount  output  $clog2(MAX_PENDING+1)  number of queued blinks; registered.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - ledOut=1, busy=0, overflow=0, pendingCount=0.
  - FSM=IDLE, timer=0.
  - Reset mid-blink aborts the blink and discards the queue.
- FSM states:
  - IDLE.
  - ON: LED lit, timer counts ON_CYCLES.
  - GAP: LED dark, timer counts OFF_CYCLES.
- Timer:
  - Width is $clog2(max(ON_CYCLES, OFF_CYCLES)).
  - Cleared on every state entry; increments each cycle; no wrap is possible.
- IDLE:
  - eventIn=1 at edge k moves the FSM to ON at edge k.
  - The event is consumed directly and is not added to pendingCount.
- ON:
  - After exactly ON_CYCLES cycles in ON, go to GAP.
- GAP:
  - After exactly OFF_CYCLES cycles in GAP:
    - If pendingCount > 0, go to ON and decrement pendingCount.
    - Otherwise go to IDLE.
- Events while in ON or GAP:
  - If pendingCount < MAX_PENDING: pendingCount increments.
  - If pendingCount = MAX_PENDING: the event is dropped, pendingCount is unchanged, and overflow=1 for exactly one cycle on the following edge.
- Simultaneous event and GAP->ON decrement in the same cycle:
  - Net pendingCount is unchanged.
  - No overflow, even if pendingCount = MAX_PENDING.
- Simultaneous event and GAP->IDLE transition (pendingCount=0):
  - The event is queued (pendingCount=1).
  - The FSM then goes IDLE->ON on the next cycle via the queue: IDLE with pendingCount>0 behaves as an immediate GAP exit.
- Output timing:
  - ledOut = ~(state==ON | levelIn), registered.
  - An event sampled at edge k gives ledOut=0 from after edge k for exactly ON_CYCLES cycles, then 1 for OFF_CYCLES cycles.
  - busy = (state != IDLE), registered with the same timing.
- levelIn:
  - Affects ledOut only, with one cycle of latency.
  - The FSM, timer, and queue keep running underneath unchanged.
  - On release, ledOut returns to the FSM value on the next edge.
- eventIn held high for multiple cycles counts as one event per cycle. Upstream guarantees single-cycle pulses.

Test Plan:
All scenarios use ON_CYCLES=4, OFF_CYCLES=3, MAX_PENDING=2.
- Reset check: assert rst_n=0 with clk running -> ledOut=1, busy=0, overflow=0, pendingCount=0. Assert rst_n mid-ON asynchronously, between edges -> ledOut goes to 1 immediately and pendingCount=0.
- Single event: one eventIn pulse from IDLE at edge k -> ledOut=0 for exactly 4 cycles after edge k, then 1. busy=1 for 7 cycles, then 0. pendingCount stays 0.
- Queue and overflow: pulses at edges k, k+1, k+2, k+3 -> pendingCount goes 1, 2, 2; overflow=1 for one cycle after edge k+3. Exactly 3 blinks of 4 low cycles, separated by 3 high cycles. busy=1 for 21 cycles total.
- Coincident event at GAP exit with pendingCount=1 -> pendingCount stays 1, no overflow, next blink starts on schedule. Coincident event at GAP exit with pendingCount=0 -> pendingCount=1, a second blink follows.
- Steady-on override: levelIn=1 during GAP -> ledOut=0 one cycle later. Release -> ledOut=1 next cycle. Next queued blink still starts exactly at the 3-cycle GAP boundary.
- Idle levelIn: levelIn=1 for 10 cycles with no events -> ledOut=0 for 10 cycles, busy stays 0, pendingCount stays 0.
